// File: rtl/interp_block_sequencer.sv
// Per-block controller for the sub-pixel interpolation datapath: row fill, filter wait, row emit.
// Optional stall counter output is enabled by defining INTERP_SEQ_PERF_EN.
module interp_block_sequencer #(
    parameter int unsigned ROWS_FULL = 15,
    parameter int unsigned ROWS_OUT  = 8,
    parameter int unsigned FILT_LAT  = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_frac_x,
    input  logic [1:0]  i_frac_y,
    input  logic        i_src_valid,
    output logic        o_src_ready,
    output logic        o_in_load_l,
    output logic        o_out_load_l,
    output logic [7:0]  o_out_sel,
    output logic [3:0]  o_cfg_frac,
    output logic        o_busy,
    output logic        o_done
`ifdef INTERP_SEQ_PERF_EN
    ,
    output logic [15:0] o_stall_cnt
`endif
);

    localparam int unsigned WAIT_W = (FILT_LAT > 0) ? $clog2(FILT_LAT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StWait,
        StEmit,
        StDone
    } state_e;

    state_e            r_state;
    logic [4:0]        r_row_cnt;
    logic [4:0]        r_rows_needed;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_out_load_l;
    logic [7:0]        r_out_sel;
    logic [3:0]        r_cfg_frac;

    logic w_src_ready;
    logic w_accept;
    logic w_last_row;
    logic w_wait_over;
    logic w_last_out;

    // Handshake is combinational so each accepted row shifts in the same cycle.
    assign w_src_ready = (r_state == StFill);
    assign w_accept    = w_src_ready & i_src_valid;
    assign w_last_row  = ((r_row_cnt + 5'd1) == r_rows_needed);
    // FILT_LAT of zero still spends one cycle in WAIT.
    assign w_wait_over = ((32'(r_wait_cnt) + 32'd1) >= FILT_LAT);
    assign w_last_out  = (r_out_sel == 8'(ROWS_OUT - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_row_cnt     <= 5'd0;
            r_rows_needed <= 5'd0;
            r_wait_cnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_out_load_l  <= 1'b1;
            r_out_sel     <= 8'd0;
            r_cfg_frac    <= 4'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_cfg_frac    <= {i_frac_y, i_frac_x};
                        r_row_cnt     <= 5'd0;
                        // Zero vertical phase bypasses the vertical taps.
                        r_rows_needed <= (i_frac_y == 2'd0) ? 5'(ROWS_OUT) : 5'(ROWS_FULL);
                        r_busy        <= 1'b1;
                        r_state       <= StFill;
                    end
                end
                StFill: begin
                    if (w_accept) begin
                        r_row_cnt <= r_row_cnt + 5'd1;
                        if (w_last_row) begin
                            r_wait_cnt <= '0;
                            r_state    <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (w_wait_over) begin
                        r_out_load_l <= 1'b0;
                        r_out_sel    <= 8'd0;
                        r_state      <= StEmit;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                StEmit: begin
                    if (w_last_out) begin
                        r_out_load_l <= 1'b1;
                        r_done       <= 1'b1;
                        r_state      <= StDone;
                    end else begin
                        r_out_sel <= r_out_sel + 8'd1;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef INTERP_SEQ_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == StIdle) && i_start) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == StFill) && !i_src_valid && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_src_ready  = w_src_ready;
    assign o_in_load_l  = ~w_accept;
    assign o_out_load_l = r_out_load_l;
    assign o_out_sel    = r_out_sel;
    assign o_cfg_frac   = r_cfg_frac;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_interp_block_sequencer.sv
// Self-checking bench for interp_block_sequencer: randomized jobs against a per-job schedule model.
module tb_interp_block_sequencer;

    localparam int ROWS_FULL = 15;
    localparam int ROWS_OUT  = 8;
    localparam int FILT_LAT  = 2;
    localparam int WAIT_LEN  = (FILT_LAT == 0) ? 1 : FILT_LAT;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] frac_x = 2'd0;
    logic [1:0] frac_y = 2'd0;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic       in_load_l;
    logic       out_load_l;
    logic [7:0] out_sel;
    logic [3:0] cfg_frac;
    logic       busy;
    logic       done;
`ifdef INTERP_SEQ_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] exp_cfg = 4'd0;
    int         exp_stall = 0;
    bit         vpat [128];

    always #5 clock = ~clock;

    interp_block_sequencer #(
        .ROWS_FULL (ROWS_FULL),
        .ROWS_OUT  (ROWS_OUT),
        .FILT_LAT  (FILT_LAT)
    ) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_start      (start),
        .i_frac_x     (frac_x),
        .i_frac_y     (frac_y),
        .i_src_valid  (src_valid),
        .o_src_ready  (src_ready),
        .o_in_load_l  (in_load_l),
        .o_out_load_l (out_load_l),
        .o_out_sel    (out_sel),
        .o_cfg_frac   (cfg_frac),
        .o_busy       (busy),
        .o_done       (done)
`ifdef INTERP_SEQ_PERF_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    // Idle cycles with random valid/frac noise; nothing may move.
    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            src_valid = 1'($urandom);
            frac_x    = 2'($urandom);
            frac_y    = 2'($urandom);
            @(negedge clock);
            n_checks += 6;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL %s idle busy got %b exp 0", tag, busy);
            end
            if (done !== 1'b0) begin
                n_fail++; $display("FAIL %s idle done got %b exp 0", tag, done);
            end
            if (src_ready !== 1'b0) begin
                n_fail++; $display("FAIL %s idle src_ready got %b exp 0", tag, src_ready);
            end
            if (in_load_l !== 1'b1) begin
                n_fail++; $display("FAIL %s idle in_load_l got %b exp 1", tag, in_load_l);
            end
            if (out_load_l !== 1'b1) begin
                n_fail++; $display("FAIL %s idle out_load_l got %b exp 1", tag, out_load_l);
            end
            if (cfg_frac !== exp_cfg) begin
                n_fail++; $display("FAIL %s idle cfg_frac got %h exp %h", tag, cfg_frac, exp_cfg);
            end
`ifdef INTERP_SEQ_PERF_EN
            n_checks++;
            if (stall_cnt !== 16'(exp_stall)) begin
                n_fail++;
                $display("FAIL %s idle stall_cnt got %0d exp %0d", tag, stall_cnt, exp_stall);
            end
`endif
            @(posedge clock);
            #1;
        end
    endtask

    // One job from the IDLE cycle that raises start. mode: 0 valid always, 1 toggling, 2 random.
    // abort_at >= 0 returns right after checking that job cycle.
    task automatic run_job(input logic [1:0] fx, input logic [1:0] fy, input int mode,
                           input bit noise, input int abort_at, input string tag);
        int need, ones, fill_len, emit_start, done_k, total;
        logic exp_ready, exp_in_l, exp_out_l;
        for (int i = 0; i < 128; i++) begin
            case (mode)
                0:       vpat[i] = 1'b1;
                1:       vpat[i] = (i % 2 == 0);
                default: vpat[i] = (i >= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
            endcase
        end
        need = (fy == 2'd0) ? ROWS_OUT : ROWS_FULL;
        ones = 0;
        fill_len = 0;
        for (int i = 0; i < 128 && fill_len == 0; i++) begin
            if (vpat[i]) ones++;
            if (ones == need) fill_len = i + 1;
        end
        emit_start = fill_len + WAIT_LEN;
        done_k     = emit_start + ROWS_OUT;
        total      = done_k + 1;

        start     = 1'b1;
        frac_x    = fx;
        frac_y    = fy;
        src_valid = 1'b1;
        @(negedge clock);
        n_checks += 3;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL %s pre-accept busy got %b exp 0", tag, busy);
        end
        if (src_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s pre-accept src_ready got %b exp 0", tag, src_ready);
        end
        if (in_load_l !== 1'b1) begin
            n_fail++; $display("FAIL %s pre-accept in_load_l got %b exp 1", tag, in_load_l);
        end
        @(posedge clock);
        #1;
        exp_cfg   = {fy, fx};
        exp_stall = fill_len - need;

        for (int k = 0; k < total; k++) begin
            start     = noise && (k == 2 || k == done_k);
            frac_x    = 2'($urandom);
            frac_y    = 2'($urandom);
            src_valid = vpat[k];
            exp_ready = (k < fill_len);
            exp_in_l  = !(exp_ready && vpat[k]);
            exp_out_l = !(k >= emit_start && k < done_k);
            @(negedge clock);
            n_checks += 6;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL %s k=%0d busy got %b exp 1", tag, k, busy);
            end
            if (done !== (k == done_k)) begin
                n_fail++;
                $display("FAIL %s k=%0d done got %b exp %b", tag, k, done, (k == done_k));
            end
            if (src_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL %s k=%0d src_ready got %b exp %b", tag, k, src_ready, exp_ready);
            end
            if (in_load_l !== exp_in_l) begin
                n_fail++;
                $display("FAIL %s k=%0d in_load_l got %b exp %b", tag, k, in_load_l, exp_in_l);
            end
            if (out_load_l !== exp_out_l) begin
                n_fail++;
                $display("FAIL %s k=%0d out_load_l got %b exp %b", tag, k, out_load_l, exp_out_l);
            end
            if (cfg_frac !== exp_cfg) begin
                n_fail++;
                $display("FAIL %s k=%0d cfg_frac got %h exp %h", tag, k, cfg_frac, exp_cfg);
            end
            if (!exp_out_l) begin
                n_checks++;
                if (out_sel !== 8'(k - emit_start)) begin
                    n_fail++;
                    $display("FAIL %s k=%0d out_sel got %0d exp %0d", tag, k, out_sel,
                             k - emit_start);
                end
            end
`ifdef INTERP_SEQ_PERF_EN
            if (k == done_k) begin
                n_checks++;
                if (stall_cnt !== 16'(exp_stall)) begin
                    n_fail++;
                    $display("FAIL %s stall_cnt got %0d exp %0d", tag, stall_cnt, exp_stall);
                end
            end
`endif
            if (k == abort_at) return;
            @(posedge clock);
            #1;
        end
        start     = 1'b0;
        src_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks += 7;
        if (src_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset src_ready got %b exp 0", src_ready);
        end
        if (in_load_l !== 1'b1) begin
            n_fail++; $display("FAIL reset in_load_l got %b exp 1", in_load_l);
        end
        if (out_load_l !== 1'b1) begin
            n_fail++; $display("FAIL reset out_load_l got %b exp 1", out_load_l);
        end
        if (out_sel !== 8'd0) begin
            n_fail++; $display("FAIL reset out_sel got %0d exp 0", out_sel);
        end
        if (cfg_frac !== 4'd0) begin
            n_fail++; $display("FAIL reset cfg_frac got %h exp 0", cfg_frac);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset busy got %b exp 0", busy);
        end
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset done got %b exp 0", done);
        end
        @(posedge clock);
        #1;
        reset     = 1'b0;
        exp_cfg   = 4'd0;
        exp_stall = 0;
        idle_cycles(2, "reset_idle");
    endtask

    task automatic test_full_vertical();
        run_job(2'd2, 2'd1, 0, 1'b0, -1, "full_vertical");
        idle_cycles(2, "full_vertical_idle");
    endtask

    task automatic test_no_vertical();
        run_job(2'($urandom), 2'd0, 0, 1'b0, -1, "no_vertical");
        idle_cycles(2, "no_vertical_idle");
    endtask

    task automatic test_stall_toggle();
        run_job(2'($urandom), 2'($urandom_range(1, 3)), 1, 1'b0, -1, "stall_toggle");
        idle_cycles(2, "stall_toggle_idle");
    endtask

    task automatic test_start_ignored();
        run_job(2'd3, 2'd2, 2, 1'b1, -1, "start_ignored");
        idle_cycles(3, "start_ignored_idle");
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 6; j++) begin
            run_job(2'($urandom), 2'($urandom), 2, 1'($urandom), -1, "random_job");
            idle_cycles($urandom_range(1, 3), "random_idle");
        end
    endtask

    task automatic test_back_to_back();
        run_job(2'($urandom), 2'($urandom_range(1, 3)), 2, 1'b0, -1, "b2b_first");
        run_job(2'($urandom), 2'd0, 0, 1'b0, -1, "b2b_second");
        run_job(2'($urandom), 2'($urandom), 2, 1'b0, -1, "b2b_third");
        idle_cycles(2, "b2b_idle");
    endtask

    task automatic test_reset_mid_emit();
        run_job(2'd1, 2'd3, 0, 1'b0, ROWS_FULL + WAIT_LEN + 3, "reset_emit");
        #2;
        reset = 1'b1;
        #1;
        n_checks += 7;
        if (src_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_emit src_ready got %b exp 0", src_ready);
        end
        if (in_load_l !== 1'b1) begin
            n_fail++; $display("FAIL reset_emit in_load_l got %b exp 1", in_load_l);
        end
        if (out_load_l !== 1'b1) begin
            n_fail++; $display("FAIL reset_emit out_load_l got %b exp 1", out_load_l);
        end
        if (out_sel !== 8'd0) begin
            n_fail++; $display("FAIL reset_emit out_sel got %0d exp 0", out_sel);
        end
        if (cfg_frac !== 4'd0) begin
            n_fail++; $display("FAIL reset_emit cfg_frac got %h exp 0", cfg_frac);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_emit busy got %b exp 0", busy);
        end
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset_emit done got %b exp 0", done);
        end
        @(posedge clock);
        #1;
        reset     = 1'b0;
        exp_cfg   = 4'd0;
        exp_stall = 0;
        idle_cycles(2, "reset_emit_idle");
        run_job(2'($urandom), 2'($urandom), 2, 1'b0, -1, "after_reset");
        idle_cycles(2, "after_reset_idle");
    endtask

    initial begin
        test_reset();
        test_full_vertical();
        test_no_vertical();
        test_stall_toggle();
        test_start_ignored();
        test_random_jobs();
        test_back_to_back();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
